// File: rtl/cpu_pkg.sv
// Shared decode constants, FSM state type and opcode-class helpers for the ID stage.
package cpu_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpLui   = 6'h0f;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    StEmpty,
    StIssue,
    StHoldLu,
    StHoldEx
  } fsm_state_e;

  // lb, lh, lwl, lw, lbu, lhu, lwr
  function automatic logic is_load_op(input logic [5:0] op);
    return op inside {[6'h20:6'h26]};
  endfunction

  // sb, sh, swl, sw, swr
  function automatic logic is_store_op(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e};
  endfunction

  // addi .. lui
  function automatic logic is_ialu_op(input logic [5:0] op);
    return op inside {[6'h08:6'h0f]};
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source operand selection: register 0, youngest matching producer, or register file.
module fwd_select
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned XLEN    = 32
) (
  input  logic [4:0]              raddr_i,
  input  logic [XLEN-1:0]         rf_rdata_i,
  input  logic [NUM_FWD-1:0]      fwd_we_i,
  input  logic [5*NUM_FWD-1:0]    fwd_waddr_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_is_load_i,
  output logic [XLEN-1:0]         value_o,
  output logic                    load_hit_o
);

  always_comb begin
    value_o    = rf_rdata_i;
    load_hit_o = 1'b0;
    // Walk oldest to youngest so the lowest matching index is the last write.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we_i[i] && (fwd_waddr_i[5*i +: 5] == raddr_i)) begin
        value_o    = fwd_wdata_i[XLEN*i +: XLEN];
        load_hit_o = fwd_is_load_i[i];
      end
    end
    if (raddr_i == REG_ZERO) begin
      value_o    = '0;
      load_hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage: IF/ID register, N-port operand forwarding, load-use interlock, branch resolve.
module id_stage_fwd
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    if_valid_i,
  input  logic [XLEN-1:0]         if_pc_i,
  input  logic [31:0]             if_inst_i,
  output logic                    id_ready_o,
  output logic [4:0]              rf_raddr1_o,
  output logic [4:0]              rf_raddr2_o,
  input  logic [XLEN-1:0]         rf_rdata1_i,
  input  logic [XLEN-1:0]         rf_rdata2_i,
  input  logic [NUM_FWD-1:0]      fwd_we_i,
  input  logic [5*NUM_FWD-1:0]    fwd_waddr_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_is_load_i,
  output logic                    ex_valid_o,
  input  logic                    ex_ready_i,
  output logic [XLEN-1:0]         ex_pc_o,
  output logic [31:0]             ex_inst_o,
  output logic [XLEN-1:0]         ex_src1_o,
  output logic [XLEN-1:0]         ex_src2_o,
  output logic                    ex_rf_we_o,
  output logic [4:0]              ex_rf_waddr_o,
  output logic                    br_taken_o,
  output logic [XLEN-1:0]         br_target_o,
  output logic [31:0]             stall_cnt_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  fsm_state_e state;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        is_rtype;

  assign opcode   = inst_q[31:26];
  assign rs       = inst_q[25:21];
  assign rt       = inst_q[20:16];
  assign rd       = inst_q[15:11];
  assign funct    = inst_q[5:0];
  assign imm      = inst_q[15:0];
  assign is_rtype = (opcode == OpRtype);

  logic uses_rs, uses_rt;

  always_comb begin
    uses_rs = 1'b1;
    if (opcode == OpLui || opcode == OpJ || opcode == OpJal) begin
      uses_rs = 1'b0;
    end
    if (is_rtype && (funct == FnSll || funct == FnSrl || funct == FnSra)) begin
      uses_rs = 1'b0;
    end
    uses_rt = is_rtype || (opcode == OpBeq) || (opcode == OpBne) || is_store_op(opcode);
  end

  logic [XLEN-1:0] src1, src2;
  logic            rs_load_hit, rt_load_hit;

  fwd_select #(
    .NUM_FWD (NUM_FWD),
    .XLEN    (XLEN)
  ) u_fwd_rs (
    .raddr_i       (rs),
    .rf_rdata_i    (rf_rdata1_i),
    .fwd_we_i      (fwd_we_i),
    .fwd_waddr_i   (fwd_waddr_i),
    .fwd_wdata_i   (fwd_wdata_i),
    .fwd_is_load_i (fwd_is_load_i),
    .value_o       (src1),
    .load_hit_o    (rs_load_hit)
  );

  fwd_select #(
    .NUM_FWD (NUM_FWD),
    .XLEN    (XLEN)
  ) u_fwd_rt (
    .raddr_i       (rt),
    .rf_rdata_i    (rf_rdata2_i),
    .fwd_we_i      (fwd_we_i),
    .fwd_waddr_i   (fwd_waddr_i),
    .fwd_wdata_i   (fwd_wdata_i),
    .fwd_is_load_i (fwd_is_load_i),
    .value_o       (src2),
    .load_hit_o    (rt_load_hit)
  );

  logic hazard;
  assign hazard = valid_q && ((uses_rs && rs_load_hit) || (uses_rt && rt_load_hit));

  // State is a pure function of the held slot, the interlock and EX backpressure.
  always_comb begin
    if (!valid_q) begin
      state = StEmpty;
    end else if (hazard) begin
      state = StHoldLu;
    end else if (!ex_ready_i) begin
      state = StHoldEx;
    end else begin
      state = StIssue;
    end
  end

  logic ex_valid, id_ready;

  always_comb begin
    ex_valid = 1'b0;
    id_ready = 1'b0;
    unique case (state)
      StEmpty:  id_ready = 1'b1;
      StIssue: begin
        ex_valid = 1'b1;
        id_ready = 1'b1;
      end
      StHoldEx: ex_valid = 1'b1;
      StHoldLu: ;
      default:  ;
    endcase
  end

  logic       rf_we;
  logic [4:0] rf_waddr;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = REG_ZERO;
    if (is_rtype) begin
      if (funct != FnJr) begin
        rf_we    = 1'b1;
        rf_waddr = rd;
      end
    end else if (opcode == OpJal) begin
      rf_we    = 1'b1;
      rf_waddr = REG_RA;
    end else if (is_ialu_op(opcode) || is_load_op(opcode)) begin
      rf_we    = 1'b1;
      rf_waddr = rt;
    end
    if (rf_waddr == REG_ZERO) begin
      rf_we = 1'b0;
    end
  end

  logic [XLEN-1:0] pc_plus4, br_offset, jmp_target;
  logic            br_cond;

  assign pc_plus4   = pc_q + XLEN'(4);
  assign br_offset  = {{(XLEN-18){imm[15]}}, imm, 2'b00};
  assign jmp_target = {pc_plus4[XLEN-1:28], inst_q[25:0], 2'b00};

  always_comb begin
    br_cond     = 1'b0;
    br_target_o = '0;
    if (is_rtype && (funct == FnJr || funct == FnJalr)) begin
      br_cond     = 1'b1;
      br_target_o = src1;
    end else begin
      unique case (opcode)
        OpBeq: begin
          br_cond     = (src1 == src2);
          br_target_o = pc_plus4 + br_offset;
        end
        OpBne: begin
          br_cond     = (src1 != src2);
          br_target_o = pc_plus4 + br_offset;
        end
        OpJ, OpJal: begin
          br_cond     = 1'b1;
          br_target_o = jmp_target;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (id_ready) begin
      // A freed slot with nothing offered empties the register.
      valid_d = if_valid_i;
      if (if_valid_i) begin
        pc_d   = if_pc_i;
        inst_d = if_inst_i;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (state == StHoldLu && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      inst_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_ready_o    = id_ready;
  assign ex_valid_o    = ex_valid;
  assign rf_raddr1_o   = rs;
  assign rf_raddr2_o   = rt;
  assign ex_pc_o       = pc_q;
  assign ex_inst_o     = inst_q;
  assign ex_src1_o     = src1;
  assign ex_src2_o     = src2;
  assign ex_rf_we_o    = rf_we;
  assign ex_rf_waddr_o = rf_waddr;
  assign br_taken_o    = ex_valid && ex_ready_i && br_cond;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/id_stage_fwd.md
# id_stage_fwd

Parametrised successor of the single-issue decode stage. It holds the IF/ID pipeline register with a valid/ready handshake and reads two source operands from the register file. Operands are forwarded from a configurable number of in-flight producer ports, and the stage interlocks on load-use hazards. Branches and jumps are resolved in ID under MIPS delay-slot semantics. It sits between the fetch stage and EX, and replaces the fixed three-port forwarding scheme.

## Interface
- `XLEN`, 32: datapath width.
- `NUM_FWD`, 3: number of forwarding producer ports. Index 0 is the youngest (EX), higher indices are older (MEM, WB, …).
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `flush` in 1: exception flush. Drops the held instruction next edge and wins over every other event.
- `if_valid` in 1: fetch offers an instruction.
- `if_pc` in XLEN: PC of the offered instruction.
- `if_inst` in 32: instruction word.
- `id_ready` out 1: ID can accept this cycle.
- `rf_raddr1`, `rf_raddr2` out 5: register-file read addresses (rs, rt of the held instruction).
- `rf_rdata1`, `rf_rdata2` in XLEN: combinational register-file read data.
- `fwd_we` in NUM_FWD: producer write enable, per port.
- `fwd_waddr` in 5*NUM_FWD: producer destination registers, packed with port i at [5i+4:5i].
- `fwd_wdata` in XLEN*NUM_FWD: producer results, packed the same way.
- `fwd_is_load` in NUM_FWD: producer result not yet available (load in flight).
- `ex_valid` out 1: bus to EX is valid.
- `ex_ready` in 1: EX accepts.
- `ex_pc` out XLEN, `ex_inst` out 32: pass-through of the held instruction.
- `ex_src1`, `ex_src2` out XLEN: forwarded rs and rt values.
- `ex_rf_we` out 1, `ex_rf_waddr` out 5: destination decode.
- `br_taken` out 1, `br_target` out XLEN: redirect to fetch.
- `stall_cnt` out 32: saturating count of load-use interlock cycles.

## Operation
- **Pipeline register.** Holds `valid_r`, `pc_r` and `inst_r`. It loads on `if_valid && id_ready`.
- **Source usage.**
  - `uses_rs` is 0 for lui, j, jal and for R-type funct 000000, 000010 and 000011 (sll/srl/sra). It is 1 otherwise.
  - `uses_rt` is 1 for R-type, beq, bne and stores. It is 0 otherwise.
- **Forwarding, per source.**
  - Register 0 always yields 0.
  - Otherwise, scan the ports and take the lowest index i with `fwd_we[i]` set and `fwd_waddr[i]` equal to the source address; the value is `fwd_wdata[i]`.
  - If no port matches, use `rf_rdata`.
- **Load-use hazard.** Raised when the winning port for a used source has `fwd_is_load` set.
- **Destination decode.** R-type writes rd, except jr, which does not write. jal writes register 31. I-type ALU and load instructions write rt. Stores and branches do not write. A write to register 0 forces `ex_rf_we` to 0.
- **Branch resolution.**
  - beq and bne compare the forwarded values. The target is `pc_r + 4 + (sext(imm) << 2)`.
  - j and jal target `{pc_r+4 [XLEN-1:28], index, 2'b00}`.
  - jr and jalr target `ex_src1`.
  - jal and jalr pass `ex_pc`; EX computes the link value as `pc + 8`.
- **FSM.**
  - States: EMPTY (`valid_r`=0), ISSUE (valid, no hazard), HOLD_LU (valid, load-use hazard), HOLD_EX (valid, no hazard, `ex_ready`=0).
  - The state is recomputed every cycle from `valid_r`, the hazard and `ex_ready`. Exactly one state is active.
- **Outputs by state.**
  - `ex_valid` = ISSUE or HOLD_EX.
  - `id_ready` = EMPTY, or (ISSUE and `ex_ready`=1).
  - `br_taken` is asserted only when the branch instruction transfers, i.e. `ex_valid && ex_ready` and the branch condition is met.
  - The delay-slot instruction is never squashed by ID.
- **Stall counter.** `stall_cnt` increments once per cycle spent in HOLD_LU and saturates at 0xFFFF_FFFF.

## Timing
- Reset: `valid_r`=0 and `stall_cnt`=0. All registered fields reset to 0. `ex_valid`=0, `br_taken`=0 and `id_ready`=1 while in reset.
- Latency: an instruction accepted at edge N is presented to EX in the cycle after edge N, provided no hazard.
- Load-use: the instruction stays in HOLD_LU with `ex_valid`=0, so EX sees a bubble. Operands are re-evaluated every cycle. The instruction issues in the first cycle the hazard is gone.
- Hazard and `ex_ready`=0 together: the state is HOLD_LU, and `stall_cnt` counts.
- Same-cycle issue and accept: when ISSUE and `ex_ready`=1, a new instruction loads on the same edge, giving full throughput.
- Fetch offers nothing when a slot frees: if ISSUE and `ex_ready`=1 but `if_valid`=0, `valid_r` clears.
- Flush: on the next edge `valid_r` clears, whether or not `if_valid` is set and whatever the state. `stall_cnt` is unaffected.
- Asynchronous reset mid-hold discards the held instruction immediately.
- `br_taken` and `br_target` are combinational and valid only in the transfer cycle.

## Structure
- Shared package `cpu_pkg`:
  - opcode and funct constants;
  - the `fsm_state_e` enum (EMPTY/ISSUE/HOLD_LU/HOLD_EX);
  - the `REG_ZERO` and `REG_RA` constants.
- Sub-module `fwd_select`, instantiated twice (once each for rs and rt). It is combinational, with parameters NUM_FWD and XLEN. Outputs: `value` and `load_hit`.

## Test plan
- **Reset and simple issue.** Release reset, then offer `addu $3,$1,$2` with `rf_rdata` = 5 and 7 and no forwards. Required: `ex_valid` the next cycle, `ex_src1`=5, `ex_src2`=7, `ex_rf_waddr`=3, `stall_cnt`=0.
- **Forward priority.** Ports 0 and 2 both write $1, with data 0xAA and 0xBB. Required: `ex_src1`=0xAA. Retry with port 0's `fwd_we`=0; required: 0xBB. With `waddr`=0, required: `ex_src1`=0.
- **Load-use.** Port 0 has `is_load`=1 with waddr=$1 for 2 cycles while `addu` uses $1. Required: `ex_valid`=0 and `id_ready`=0 for 2 cycles, then issue with `stall_cnt`=2. sll with rt≠$1 and rs=$1 must not stall.
- **Branch.** `beq $1,$2,+4` at pc 0x100 with equal operands. Required: `br_taken`=1 and `br_target`=0x114 in the transfer cycle. With operands unequal, `br_taken`=0. jal at 0x2000_0000 with index 0x40 yields target 0x2000_0100 and waddr 31.
- **Backpressure and flush.** Hold `ex_ready`=0 for 3 cycles. Required: outputs stable, `id_ready`=0, `stall_cnt` unchanged. Assert `flush` while `if_valid`=1; required: `ex_valid`=0 the next cycle.
- **Throughput and asynchronous reset.** A back-to-back stream of 8 instructions with `ex_ready`=1 must give 8 consecutive `ex_valid` cycles. Assert `rst`=0 asynchronously mid-HOLD_LU; required: `ex_valid` drops before the next edge and `stall_cnt`=0.
